// File: rtl/pipe_skid_stage.sv
// Valid/stall pipeline stage with a two-entry skid buffer.
// The upstream stall is decoded from the state register, so it never depends
// combinationally on downstream stall. With SRC_MODE set, the stage sources
// its own data from a counter and ignores the upstream valid/data inputs.
module pipe_skid_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SRC_MODE = 0,
  parameter int unsigned CNT_STEP = 1,
  parameter int unsigned XCNT_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_internal_stall,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_stall,
  output logic [XCNT_W-1:0] o_xfer_cnt
);

  // Occupancy states: nothing held, out register held, out and skid held.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam bit                SRC_INT = (SRC_MODE != 0);
  localparam logic [DATA_W-1:0] STEP    = DATA_W'(CNT_STEP);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [XCNT_W-1:0] xcnt_q, xcnt_d;

  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              out_full;
  logic              accept;
  logic              xfer;

  // Data source selection: upstream port or internal counter.
  assign src_valid = SRC_INT ? 1'b1 : i_valid;
  assign src_data  = SRC_INT ? cnt_q : i_data;

  // Handshakes; o_valid is the only output gated combinationally.
  assign out_full = (state_q != ST_EMPTY);
  assign o_stall  = (state_q == ST_FULL);
  assign o_valid  = out_full & ~i_internal_stall & ~i_flush;
  assign accept   = src_valid & ~o_stall & ~i_flush;
  assign xfer     = o_valid & ~i_stall;

  assign o_data     = out_q;
  assign o_xfer_cnt = xcnt_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
      xcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
      xcnt_q  <= xcnt_d;
    end
  end

  // Next-state, skid steering and counter updates; flush overrides all.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    xcnt_d  = xcnt_q;

    if (i_flush) begin
      state_d = ST_EMPTY;
      out_d   = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            out_d   = src_data;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            out_d = src_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = src_data;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Upstream is stalled here, so only the drain path exists.
          if (xfer) begin
            state_d = ST_ONE;
            out_d   = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase

      if (accept && SRC_INT) begin
        cnt_d = cnt_q + STEP;
      end
      if (xfer) begin
        xcnt_d = xcnt_q + XCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized bench for pipe_skid_stage: three configurations run side by side
// (pass-through, counter source with step 3, 4-bit counter source with a
// narrow transfer counter), each compared every cycle to a queue-based model.
module tb_pipe_skid_stage;

  logic clk;
  logic rst;
  logic quiet;
  logic force_stall;
  logic force_flush;

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int unsigned DW = (g == 2) ? 4 : 16;
    localparam int unsigned SM = (g == 0) ? 0 : 1;
    localparam int unsigned ST = (g == 1) ? 3 : 1;
    localparam int unsigned XW = (g == 2) ? 6 : 32;

    logic          flush;
    logic          istall;
    logic          valid_in;
    logic [DW-1:0] din;
    logic          stall_in;
    logic          ostall;
    logic          ovalid;
    logic [DW-1:0] dout;
    logic [XW-1:0] xcnt;

    pipe_skid_stage #(
      .DATA_W  (DW),
      .SRC_MODE(SM),
      .CNT_STEP(ST),
      .XCNT_W  (XW)
    ) u_dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_flush         (flush),
      .i_internal_stall(istall),
      .i_valid         (valid_in),
      .i_data          (din),
      .o_stall         (ostall),
      .o_valid         (ovalid),
      .o_data          (dout),
      .i_stall         (stall_in),
      .o_xfer_cnt      (xcnt)
    );

    // Reference: a FIFO of at most two held data plus the last value shown.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    logic [DW-1:0] m_cnt;
    logic [XW-1:0] m_xcnt;

    initial begin : drive
      logic          e_full;
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic          src_v;
      logic [DW-1:0] src_d;
      logic          acc;
      logic          xf;
      flush = 1'b0; istall = 1'b0; valid_in = 1'b0; din = '0; stall_in = 1'b0;
      mq.delete(); m_last = '0; m_cnt = '0; m_xcnt = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          mq.delete(); m_last = '0; m_cnt = '0; m_xcnt = '0;
          flush = 1'b0; istall = 1'b0; valid_in = 1'b0; din = '0; stall_in = 1'b0;
          #1;
          check($sformatf("l%0d_rst_valid", g), 64'(ovalid), 64'd0);
          check($sformatf("l%0d_rst_stall", g), 64'(ostall), 64'd0);
          check($sformatf("l%0d_rst_data", g), 64'(dout), 64'd0);
          check($sformatf("l%0d_rst_xcnt", g), 64'(xcnt), 64'd0);
          continue;
        end
        flush    = force_flush | (!quiet && ($urandom_range(15) == 0));
        istall   = !quiet && ($urandom_range(3) == 0);
        stall_in = force_stall | (!quiet && ($urandom_range(2) == 0));
        valid_in = quiet ? 1'b1 : 1'($urandom_range(1));
        din      = DW'($urandom);
        #1;
        e_full  = (mq.size() == 2);
        e_valid = (mq.size() > 0) && !istall && !flush;
        e_data  = (mq.size() > 0) ? mq[0] : m_last;
        check($sformatf("l%0d_stall", g), 64'(ostall), 64'(e_full));
        check($sformatf("l%0d_valid", g), 64'(ovalid), 64'(e_valid));
        check($sformatf("l%0d_data", g), 64'(dout), 64'(e_data));
        check($sformatf("l%0d_xcnt", g), 64'(xcnt), 64'(m_xcnt));
        src_v = (SM != 0) ? 1'b1 : valid_in;
        src_d = (SM != 0) ? m_cnt : din;
        acc   = src_v && !e_full && !flush;
        xf    = e_valid && !stall_in;
        if (flush) begin
          mq.delete();
          m_last = '0;
        end else begin
          if (xf) begin
            m_last = mq.pop_front();
            m_xcnt = XW'((longint'(m_xcnt) + 1) % (longint'(1) << XW));
          end
          if (acc) begin
            mq.push_back(src_d);
            if (SM != 0) m_cnt = DW'((longint'(m_cnt) + longint'(ST)) % (longint'(1) << DW));
          end
        end
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    quiet = 1'b1;
    force_stall = 1'b0;
    force_flush = 1'b0;
    wait_edges(3);
    rst = 1'b0;

    // Free-running throughput, includes the 4-bit counter wrap.
    wait_edges(20);
    quiet = 1'b0;
    wait_edges(400);

    // Fill every lane, then flush while full.
    quiet = 1'b1;
    force_stall = 1'b1;
    wait_edges(4);
    force_flush = 1'b1;
    wait_edges(1);
    force_flush = 1'b0;
    wait_edges(4);

    // Asynchronous reset between edges while full.
    check("l0_full_pre_rst", 64'(lane[0].ostall), 64'd1);
    check("l1_full_pre_rst", 64'(lane[1].ostall), 64'd1);
    check("l2_full_pre_rst", 64'(lane[2].ostall), 64'd1);
    rst = 1'b1;
    #1;
    check("l0_async_valid", 64'(lane[0].ovalid), 64'd0);
    check("l1_async_stall", 64'(lane[1].ostall), 64'd0);
    check("l1_async_data", 64'(lane[1].dout), 64'd0);
    check("l2_async_xcnt", 64'(lane[2].xcnt), 64'd0);
    force_stall = 1'b0;
    wait_edges(2);
    rst = 1'b0;

    wait_edges(20);
    quiet = 1'b0;
    wait_edges(600);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
